peak_dpu_lsu: RTL and testbench

Load/store execution unit of the DPU. It consumes one decoded ld/st operation per transaction (op code, base, immediate, store data, destination register) from the decode/issue stage. It performs the data-memory access over a req/gnt/rvld bus and returns sign- or zero-extended load data to the register-file writeback port. Only one transaction is outstanding at a time; the unit detects misaligned addresses and raises an exception without touching the bus.

---
 rtl/peak_dpu_pkg.sv | 87 ++++++++
 rtl/peak_dpu_lsu_if.sv | 41 ++++
 rtl/peak_dpu_lsu_align.sv | 19 +
 rtl/peak_dpu_lsu.sv | 173 +++++++++++++++++
 tb/tb_peak_dpu_lsu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/peak_dpu_pkg.sv
// Shared DPU load/store definitions: op encodings, LSU state encoding and
// the byte-enable / store-replication / load-extract helpers. The decoder
// and the LSU both import these so the encodings can never drift apart.
package peak_dpu_pkg;

  localparam logic [2:0] LS_LB  = 3'd0;
  localparam logic [2:0] LS_LH  = 3'd1;
  localparam logic [2:0] LS_LW  = 3'd2;
  localparam logic [2:0] LS_LBU = 3'd3;
  localparam logic [2:0] LS_LHU = 3'd4;
  localparam logic [2:0] LS_SB  = 3'd5;
  localparam logic [2:0] LS_SH  = 3'd6;
  localparam logic [2:0] LS_SW  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ls_size_e;

  function automatic ls_size_e ls_size(input logic [2:0] op);
    ls_size_e sz;
    case (op)
      LS_LB, LS_LBU, LS_SB: sz = SZ_BYTE;
      LS_LH, LS_LHU, LS_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic ls_is_store(input logic [2:0] op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

  function automatic logic ls_misaligned(input logic [2:0] op, input logic [1:0] ea_lo);
    logic mis;
    case (ls_size(op))
      SZ_HALF: mis = ea_lo[0];
      SZ_WORD: mis = (ea_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] ls_be(input logic [2:0] op, input logic [1:0] ea_lo);
    logic [3:0] be;
    case (ls_size(op))
      SZ_BYTE: be = 4'b0001 << ea_lo;
      SZ_HALF: be = 4'b0011 << ea_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane so the byte enables alone
  // select which bytes memory writes.
  function automatic logic [31:0] ls_wdata(input logic [2:0] op, input logic [31:0] sdata);
    logic [31:0] wd;
    case (ls_size(op))
      SZ_BYTE: wd = {4{sdata[7:0]}};
      SZ_HALF: wd = {2{sdata[15:0]}};
      default: wd = sdata;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] ls_extract(input logic [2:0] op, input logic [1:0] ea_lo,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {ea_lo, 3'b000};
    case (op)
      LS_LB:   res = {{24{sh[7]}}, sh[7:0]};
      LS_LH:   res = {{16{sh[15]}}, sh[15:0]};
      LS_LBU:  res = {24'h000000, sh[7:0]};
      LS_LHU:  res = {16'h0000, sh[15:0]};
      LS_LW:   res = sh;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/peak_dpu_lsu_if.sv
// Issue, data-memory and writeback signals of the DPU load/store unit.
// master = the LSU itself, slave = its environment (issue stage, memory, RF).
interface peak_dpu_lsu_if #(parameter int DW = 32);
  logic          ls_vld;
  logic          ls_rdy;
  logic [2:0]    ls_op;
  logic [DW-1:0] ls_base;
  logic [DW-1:0] ls_imm;
  logic [DW-1:0] ls_sdata;
  logic [4:0]    ls_wr_addr;

  logic          dmem_req;
  logic          dmem_gnt;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_rvld;
  logic [DW-1:0] dmem_rdata;

  logic          wb_vld;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          ls_done;
  logic          ls_misalign;
  logic [DW-1:0] ls_bad_addr;

  modport master (
    input  ls_vld, ls_op, ls_base, ls_imm, ls_sdata, ls_wr_addr,
    input  dmem_gnt, dmem_rvld, dmem_rdata,
    output ls_rdy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_vld, wb_addr, wb_data, ls_done, ls_misalign, ls_bad_addr
  );

  modport slave (
    output ls_vld, ls_op, ls_base, ls_imm, ls_sdata, ls_wr_addr,
    output dmem_gnt, dmem_rvld, dmem_rdata,
    input  ls_rdy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_vld, wb_addr, wb_data, ls_done, ls_misalign, ls_bad_addr
  );
endinterface

// File: rtl/peak_dpu_lsu_align.sv
// Lane alignment for the LSU: byte enables, store-data replication,
// load-data extraction/extension and misalignment detection. Combinational.
module peak_dpu_lsu_align
  import peak_dpu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);
  assign be_o       = ls_be(op_i, ea_lo_i);
  assign wdata_o    = ls_wdata(op_i, sdata_i);
  assign wb_data_o  = ls_extract(op_i, ea_lo_i, rdata_i);
  assign misalign_o = ls_misaligned(op_i, ea_lo_i);
endmodule

// File: rtl/peak_dpu_lsu.sv
// DPU load/store unit: one ld/st in flight, req/gnt/rvld data bus,
// sign/zero-extended writeback, misaligned ops trapped without a bus access.
module peak_dpu_lsu
  import peak_dpu_pkg::*;
#(
  parameter int DW = 32
)(
  input  logic           clk,
  input  logic           rst_n,
  peak_dpu_lsu_if.master bus
);
  logic [1:0]    state_q,   state_d;
  logic [2:0]    op_q,      op_d;
  logic [1:0]    ea_lo_q,   ea_lo_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic          req_q,     req_d;
  logic          we_q,      we_d;
  logic [DW-1:0] addr_q,    addr_d;
  logic [3:0]    be_q,      be_d;
  logic [DW-1:0] wdata_q,   wdata_d;
  logic          wb_vld_q,  wb_vld_d;
  logic [4:0]    wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          done_q,    done_d;
  logic          mis_q,     mis_d;
  logic [DW-1:0] bad_q,     bad_d;

  logic [DW-1:0] ea;
  logic          idle;
  logic [2:0]    al_op;
  logic [1:0]    al_ea_lo;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_wb_data;
  logic          al_misalign;

  assign ea   = bus.ls_base + bus.ls_imm;
  assign idle = (state_q == ST_IDLE);

  // The aligner serves the incoming op while idle and the held op afterwards.
  assign al_op    = idle ? bus.ls_op : op_q;
  assign al_ea_lo = idle ? ea[1:0]   : ea_lo_q;

  peak_dpu_lsu_align u_align (
    .op_i       (al_op),
    .ea_lo_i    (al_ea_lo),
    .sdata_i    (bus.ls_sdata),
    .rdata_i    (bus.dmem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .wb_data_o  (al_wb_data),
    .misalign_o (al_misalign)
  );

  // Next-state and next-output logic of the issue/request/response FSM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ea_lo_d   = ea_lo_q;
    wr_addr_d = wr_addr_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wb_vld_d  = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    bad_d     = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ls_vld) begin
          op_d      = bus.ls_op;
          ea_lo_d   = ea[1:0];
          wr_addr_d = bus.ls_wr_addr;
          if (al_misalign) begin
            mis_d = 1'b1;
            bad_d = ea;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = ls_is_store(bus.ls_op);
            addr_d  = {ea[DW-1:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus.dmem_rvld) begin
          wb_vld_d  = 1'b1;
          done_d    = 1'b1;
          wb_addr_d = wr_addr_q;
          wb_data_d = al_wb_data;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'd0;
      ea_lo_q   <= 2'd0;
      wr_addr_q <= 5'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'd0;
      wdata_q   <= '0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ea_lo_q   <= ea_lo_d;
      wr_addr_q <= wr_addr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wb_vld_q  <= wb_vld_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.ls_rdy      = idle;
  assign bus.dmem_req    = req_q;
  assign bus.dmem_we     = we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_be     = be_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.wb_vld      = wb_vld_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.ls_done     = done_q;
  assign bus.ls_misalign = mis_q;
  assign bus.ls_bad_addr = bad_q;
endmodule

// File: tb/tb_peak_dpu_lsu.sv
// Bench for peak_dpu_lsu: directed vector table, random ops against a
// lane-level reference model, and a reset-during-response sequence.
module tb_peak_dpu_lsu;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peak_dpu_lsu_if #(.DW(32)) bus ();
  peak_dpu_lsu #(.DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] sdata;
    logic [4:0]  wr;
    logic [31:0] rdata;
    int          gdly;
    int          gap;
    bit          b2b;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    bit          e_mis;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm,
                              input logic [31:0] sdata, input logic [4:0] wr, input logic [31:0] rdata,
                              input int gdly, input int gap, input bit b2b,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_wb, input bit e_mis);
    vec_t v;
    v.op = op; v.base = base; v.imm = imm; v.sdata = sdata; v.wr = wr; v.rdata = rdata;
    v.gdly = gdly; v.gap = gap; v.b2b = b2b;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_mis = e_mis;
    return v;
  endfunction

  // Reference model: access size in bytes, lane offset, plain arithmetic.
  function automatic vec_t model(input vec_t v);
    int sz;
    int off;
    logic [31:0] ea;
    logic [31:0] sh;
    logic [31:0] mask;
    ea  = v.base + v.imm;
    off = int'(ea % 32'd4);
    case (v.op)
      3'd0, 3'd3, 3'd5: sz = 1;
      3'd1, 3'd4, 3'd6: sz = 2;
      default:          sz = 4;
    endcase
    v.e_mis  = (ea % sz) != 0;
    v.e_addr = ea & 32'hFFFF_FFFC;
    v.e_be   = 4'(((1 << sz) - 1) << off);
    v.e_wdata = 32'h0;
    for (int lane = 0; lane < 4; lane++)
      v.e_wdata[8*lane +: 8] = v.sdata[8*(lane % sz) +: 8];
    sh = v.rdata >> (8 * off);
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      sh = sh & mask;
      if ((v.op == 3'd0 || v.op == 3'd1) && sh[8*sz-1]) sh = sh | ~mask;
    end
    v.e_wb = sh;
    return v;
  endfunction

  task automatic do_op(input vec_t v);
    bit st;
    st = (v.op >= 3'd5);
    bus.ls_vld = 1'b1; bus.ls_op = v.op; bus.ls_base = v.base; bus.ls_imm = v.imm;
    bus.ls_sdata = v.sdata; bus.ls_wr_addr = v.wr;
    chk("issue_rdy", bus.ls_rdy, 1);
    tick();
    bus.ls_vld = 1'b0;
    bus.ls_sdata = $urandom;
    if (v.e_mis) begin
      chk("mis_pulse", bus.ls_misalign, 1);
      chk("mis_bad_addr", bus.ls_bad_addr, v.base + v.imm);
      chk("mis_no_req", bus.dmem_req, 0);
      chk("mis_rdy", bus.ls_rdy, 1);
      chk("mis_no_done", bus.ls_done, 0);
      chk("mis_no_wb", bus.wb_vld, 0);
    end else begin
      chk("req", bus.dmem_req, 1);
      chk("addr", bus.dmem_addr, v.e_addr);
      chk("be", bus.dmem_be, v.e_be);
      chk("we", bus.dmem_we, st);
      chk("rdy_low", bus.ls_rdy, 0);
      if (st) chk("wdata", bus.dmem_wdata, v.e_wdata);
      for (int g = 0; g < v.gdly; g++) begin
        bus.dmem_gnt = 1'b0;
        bus.dmem_rvld = 1'($urandom);
        tick();
        chk("req_hold", bus.dmem_req, 1);
        chk("addr_hold", bus.dmem_addr, v.e_addr);
        chk("be_hold", bus.dmem_be, v.e_be);
        chk("wait_no_done", bus.ls_done, 0);
      end
      bus.dmem_rvld = 1'b0;
      bus.dmem_gnt = 1'b1;
      tick();
      bus.dmem_gnt = 1'b0;
      if (st) begin
        chk("st_done", bus.ls_done, 1);
        chk("st_no_wb", bus.wb_vld, 0);
        chk("st_req_drop", bus.dmem_req, 0);
        chk("st_rdy", bus.ls_rdy, 1);
      end else begin
        chk("ld_req_drop", bus.dmem_req, 0);
        chk("ld_resp_rdy", bus.ls_rdy, 0);
        chk("ld_resp_no_done", bus.ls_done, 0);
        for (int i = 0; i < v.gap; i++) begin
          bus.dmem_rdata = $urandom;
          tick();
          chk("ld_wait_no_wb", bus.wb_vld, 0);
          chk("ld_wait_rdy", bus.ls_rdy, 0);
        end
        bus.dmem_rvld = 1'b1;
        bus.dmem_rdata = v.rdata;
        tick();
        bus.dmem_rvld = 1'b0;
        bus.dmem_rdata = $urandom;
        chk("ld_wb_vld", bus.wb_vld, 1);
        chk("ld_done", bus.ls_done, 1);
        chk("ld_wb_addr", bus.wb_addr, v.wr);
        chk("ld_wb_data", bus.wb_data, v.e_wb);
        chk("ld_rdy", bus.ls_rdy, 1);
      end
    end
    if (!v.b2b) begin
      tick();
      chk("pulse_done_end", bus.ls_done, 0);
      chk("pulse_wb_end", bus.wb_vld, 0);
      chk("pulse_mis_end", bus.ls_misalign, 0);
      chk("idle_req", bus.dmem_req, 0);
      chk("idle_rdy", bus.ls_rdy, 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, bus.dmem_req, 0);
    chk({tag, "_we"}, bus.dmem_we, 0);
    chk({tag, "_addr"}, bus.dmem_addr, 0);
    chk({tag, "_be"}, bus.dmem_be, 0);
    chk({tag, "_wdata"}, bus.dmem_wdata, 0);
    chk({tag, "_wb_vld"}, bus.wb_vld, 0);
    chk({tag, "_wb_addr"}, bus.wb_addr, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_done"}, bus.ls_done, 0);
    chk({tag, "_mis"}, bus.ls_misalign, 0);
    chk({tag, "_bad"}, bus.ls_bad_addr, 0);
    chk({tag, "_rdy"}, bus.ls_rdy, 1);
  endtask

  initial begin
    vec_t v;
    //            op    base          imm           sdata         wr     rdata         gd gp b2b e_addr        e_be     e_wdata       e_wb          mis
    tbl[0] = mk(3'd7, 32'h0000_1000, 32'h0000_0004, 32'hDEAD_BEEF, 5'd0,  32'h0,        0, 0, 0, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0);
    tbl[1] = mk(3'd0, 32'h0000_2000, 32'h0000_0003, 32'h0,         5'd9,  32'h80FF_FFFF, 3, 1, 0, 32'h0000_2000, 4'b1000, 32'h0,        32'hFFFF_FF80, 0);
    tbl[2] = mk(3'd3, 32'h0000_2000, 32'h0000_0003, 32'h0,         5'd7,  32'h8000_0000, 0, 0, 0, 32'h0000_2000, 4'b1000, 32'h0,        32'h0000_0080, 0);
    tbl[3] = mk(3'd4, 32'h0000_2000, 32'h0000_0002, 32'h0,         5'd12, 32'hBEEF_0000, 1, 0, 0, 32'h0000_2000, 4'b1100, 32'h0,        32'h0000_BEEF, 0);
    tbl[4] = mk(3'd2, 32'h0000_1000, 32'hFFFF_FFFE, 32'h0,         5'd3,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
    tbl[5] = mk(3'd6, 32'h0000_3000, 32'h0000_0002, 32'h0000_1234, 5'd0,  32'h0,        0, 0, 1, 32'h0000_3000, 4'b1100, 32'h1234_1234, 32'h0,        0);
    tbl[6] = mk(3'd5, 32'h0000_3000, 32'h0000_0001, 32'h0000_00A5, 5'd0,  32'h0,        2, 0, 0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0);
    tbl[7] = mk(3'd1, 32'h0000_4000, 32'h0000_0002, 32'h0,         5'd31, 32'h8001_0000, 0, 2, 1, 32'h0000_4000, 4'b1100, 32'h0,        32'hFFFF_8001, 0);
    tbl[8] = mk(3'd2, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0,         5'd0,  32'h1234_5678, 0, 0, 1, 32'h0000_0000, 4'b1111, 32'h0,        32'h1234_5678, 0);
    tbl[9] = mk(3'd1, 32'h0000_5000, 32'h0000_0001, 32'h0,         5'd4,  32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1);

    rst_n = 1'b0;
    bus.ls_vld = 1'b0; bus.ls_op = 3'd0; bus.ls_base = 32'h0; bus.ls_imm = 32'h0;
    bus.ls_sdata = 32'h0; bus.ls_wr_addr = 5'd0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvld = 1'b0; bus.dmem_rdata = 32'h0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) do_op(tbl[i]);

    for (int n = 0; n < 200; n++) begin
      v = mk(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 15)), $urandom, 5'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 32'h0, 4'h0, 32'h0, 32'h0, 0);
      if ($urandom_range(0, 7) == 0) v.imm = $urandom;
      v = model(v);
      do_op(v);
    end

    // Reset while a load waits for its response.
    bus.ls_vld = 1'b1; bus.ls_op = 3'd2; bus.ls_base = 32'h0000_0100; bus.ls_imm = 32'h0000_0008;
    bus.ls_wr_addr = 5'd17;
    tick();
    bus.ls_vld = 1'b0;
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chk("rst_pre_resp_rdy", bus.ls_rdy, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_rvld = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    tick();
    bus.dmem_rvld = 1'b0;
    chk("late_rvld_no_wb", bus.wb_vld, 0);
    chk("late_rvld_no_done", bus.ls_done, 0);
    chk("late_rvld_rdy", bus.ls_rdy, 1);
    chk("late_rvld_no_req", bus.dmem_req, 0);
    tick();
    chk("late_rvld_no_wb2", bus.wb_vld, 0);
    do_op(tbl[1]);
    do_op(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
